// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load-op encodings, default widths and a constant clog2.
package cpu_pkg;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_B    = 3'd1,
        LD_BU   = 3'd2,
        LD_H    = 3'd3,
        LD_HU   = 3'd4,
        LD_W    = 3'd5,
        LD_WU   = 3'd6,
        LD_D    = 3'd7
    } ld_op_e;

    localparam int PC_W_DEF    = 32;
    localparam int RADDR_W_DEF = 5;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load lane select and sign/zero extension for DATA_W of 32 or 64.
module load_extend
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        load_op,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] result
);

    localparam int LANE_W = clog2(DATA_W / 8);

    logic [LANE_W-1:0] off_s;
    logic [LANE_W-1:0] off_h_s;
    logic [LANE_W-1:0] off_w_s;
    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic [31:0]       word_s;

    // Halfword/word lanes come from the offset with its low bits masked, so the
    // same expressions work whether or not a word offset bit exists.
    assign off_s   = alu_res[LANE_W-1:0];
    assign off_h_s = off_s & ~LANE_W'(1'b1);
    assign off_w_s = off_s & ~LANE_W'(2'b11);
    assign byte_s  = 8'(rdata >> {off_s, 3'b000});
    assign half_s  = 16'(rdata >> {off_h_s, 3'b000});
    assign word_s  = 32'(rdata >> {off_w_s, 3'b000});

    // Select and extend the addressed lane; non-loads pass the ALU result through.
    always_comb begin
        result = alu_res;
        case (load_op)
            LD_NONE: result = alu_res;
            LD_B:    result = DATA_W'($signed(byte_s));
            LD_BU:   result = DATA_W'(byte_s);
            LD_H:    result = DATA_W'($signed(half_s));
            LD_HU:   result = DATA_W'(half_s);
            LD_W:    result = DATA_W'($signed(word_s));
            LD_WU:   result = DATA_W'(word_s);
            LD_D:    result = rdata;
            default: result = alu_res;
        endcase
    end

endmodule

// File: rtl/mem_stage_pipe_chk.sv
// Property checker for mem_stage_pipe: the orphan-response counter never saturates.
module mem_stage_pipe_chk (
    input logic       clk,
    input logic       resetn,
    input logic [1:0] discard_cnt
);

    // At most two responses can be outstanding, so the counter stays below 3.
    a_no_saturate: assert property (@(posedge clk) disable iff (!resetn) (discard_cnt != 2'd3))
        else $error("mem_stage_pipe discard counter reached 3");

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage with data_ok handshake, one-entry response buffer and flush discard.
// Optional ms_fwd_valid output is enabled by defining MEM_STAGE_BYPASS_EN.
module mem_stage_pipe
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int PC_W    = PC_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               es_to_ms_valid,
    input  logic               ws_allowin,
    output logic               ms_allowin,
    output logic               ms_to_ws_valid,
    input  logic [PC_W-1:0]    es_pc,
    input  logic [DATA_W-1:0]  es_alu_res,
    input  logic [2:0]         es_load_op,
    input  logic               es_mem_req,
    input  logic               es_rf_we,
    input  logic [RADDR_W-1:0] es_rf_waddr,
    input  logic               data_sram_data_ok,
    input  logic [DATA_W-1:0]  data_sram_rdata,
    output logic [PC_W-1:0]    ms_pc,
    output logic [DATA_W-1:0]  ms_rf_wdata,
    output logic               ms_rf_we,
    output logic [RADDR_W-1:0] ms_rf_waddr,
    output logic               ms_blocking
`ifdef MEM_STAGE_BYPASS_EN
    ,
    output logic               ms_fwd_valid
`endif
);

    logic               ms_valid_q,       ms_valid_d;
    logic [PC_W-1:0]    pc_q,             pc_d;
    logic [DATA_W-1:0]  alu_res_q,        alu_res_d;
    logic [2:0]         load_op_q,        load_op_d;
    logic               rf_we_q,          rf_we_d;
    logic [RADDR_W-1:0] rf_waddr_q,       rf_waddr_d;
    logic               wait_resp_q,      wait_resp_d;
    logic               resp_buf_valid_q, resp_buf_valid_d;
    logic [DATA_W-1:0]  resp_buf_q,       resp_buf_d;
    logic [1:0]         discard_cnt_q,    discard_cnt_d;

    logic               resp_hit_s;
    logic               own_resp_s;
    logic               ready_go_s;
    logic               accept_s;
    logic               fire_s;
    logic               disc_inc_s;
    logic               disc_dec_s;
    logic [DATA_W-1:0]  load_data_s;

    // A data_ok belongs to this stage only once every orphaned response has drained.
    assign resp_hit_s     = data_sram_data_ok & (discard_cnt_q == 2'd0);
    assign own_resp_s     = resp_hit_s & ms_valid_q & wait_resp_q;
    assign ready_go_s     = ~wait_resp_q | resp_buf_valid_q | resp_hit_s;
    assign ms_allowin     = ~ms_valid_q | (ready_go_s & ws_allowin);
    assign ms_to_ws_valid = ms_valid_q & ready_go_s & ~flush;
    assign accept_s       = es_to_ms_valid & ms_allowin;
    assign fire_s         = ms_to_ws_valid & ws_allowin;
    assign disc_inc_s     = flush & ms_valid_q & wait_resp_q & ~resp_buf_valid_q & ~resp_hit_s;
    assign disc_dec_s     = data_sram_data_ok & (discard_cnt_q != 2'd0);
    assign load_data_s    = resp_buf_valid_q ? resp_buf_q : data_sram_rdata;

    // Next-state logic for payload, handshake, response buffer and discard count.
    always_comb begin
        ms_valid_d       = ms_valid_q;
        pc_d             = pc_q;
        alu_res_d        = alu_res_q;
        load_op_d        = load_op_q;
        rf_we_d          = rf_we_q;
        rf_waddr_d       = rf_waddr_q;
        wait_resp_d      = wait_resp_q;
        resp_buf_valid_d = resp_buf_valid_q;
        resp_buf_d       = resp_buf_q;
        discard_cnt_d    = discard_cnt_q;

        if (accept_s) begin
            pc_d       = es_pc;
            alu_res_d  = es_alu_res;
            load_op_d  = es_load_op;
            rf_we_d    = es_rf_we;
            rf_waddr_d = es_rf_waddr;
        end else begin
            pc_d       = pc_q;
        end

        if (flush) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end else begin
            ms_valid_d = ms_valid_q;
        end

        if (flush) begin
            wait_resp_d = 1'b0;
        end else if (accept_s) begin
            wait_resp_d = es_mem_req;
        end else if (own_resp_s) begin
            wait_resp_d = 1'b0;
        end else begin
            wait_resp_d = wait_resp_q;
        end

        // A flushed instruction must not leave a stale entry for its successor.
        if (flush || fire_s) begin
            resp_buf_valid_d = 1'b0;
        end else if (own_resp_s && !ws_allowin) begin
            resp_buf_valid_d = 1'b1;
            resp_buf_d       = data_sram_rdata;
        end else begin
            resp_buf_valid_d = resp_buf_valid_q;
        end

        case ({disc_inc_s, disc_dec_s})
            2'b10:   discard_cnt_d = discard_cnt_q + 2'd1;
            2'b01:   discard_cnt_d = discard_cnt_q - 2'd1;
            default: discard_cnt_d = discard_cnt_q;
        endcase
    end

    // Stage state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q       <= 1'b0;
            pc_q             <= '0;
            alu_res_q        <= '0;
            load_op_q        <= 3'd0;
            rf_we_q          <= 1'b0;
            rf_waddr_q       <= '0;
            wait_resp_q      <= 1'b0;
            resp_buf_valid_q <= 1'b0;
            resp_buf_q       <= '0;
            discard_cnt_q    <= 2'd0;
        end else begin
            ms_valid_q       <= ms_valid_d;
            pc_q             <= pc_d;
            alu_res_q        <= alu_res_d;
            load_op_q        <= load_op_d;
            rf_we_q          <= rf_we_d;
            rf_waddr_q       <= rf_waddr_d;
            wait_resp_q      <= wait_resp_d;
            resp_buf_valid_q <= resp_buf_valid_d;
            resp_buf_q       <= resp_buf_d;
            discard_cnt_q    <= discard_cnt_d;
        end
    end

    load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .load_op (load_op_q),
        .alu_res (alu_res_q),
        .rdata   (load_data_s),
        .result  (ms_rf_wdata)
    );

    assign ms_pc       = pc_q;
    assign ms_rf_we    = rf_we_q & ms_valid_q;
    assign ms_rf_waddr = rf_waddr_q;
    assign ms_blocking = ms_valid_q & (load_op_q != 3'(LD_NONE)) & wait_resp_q & ~resp_buf_valid_q;

`ifdef MEM_STAGE_BYPASS_EN
    assign ms_fwd_valid = ms_valid_q & rf_we_q & (ready_go_s | (load_op_q == 3'(LD_NONE)));
`endif

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: a 32-bit instance plus a 64-bit instance for the wide load.
module tb_mem_stage_pipe;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        es_to_ms_valid;
    logic        ws_allowin;
    logic [31:0] es_pc;
    logic [2:0]  es_load_op;
    logic        es_mem_req;
    logic        es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic        data_ok;

    logic [31:0] es_alu_res;
    logic [31:0] rdata;
    logic        ms_allowin, ms_to_ws_valid, ms_rf_we, ms_blocking;
    logic [31:0] ms_pc, ms_rf_wdata;
    logic [4:0]  ms_rf_waddr;

    logic [63:0] es_alu_res64;
    logic [2:0]  es_load_op64;
    logic [63:0] rdata64;
    logic        ms_allowin64, ms_to_ws_valid64, ms_rf_we64, ms_blocking64;
    logic [31:0] ms_pc64;
    logic [63:0] ms_rf_wdata64;
    logic [4:0]  ms_rf_waddr64;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_stage_pipe #(.DATA_W(32)) u32 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .es_to_ms_valid(es_to_ms_valid), .ws_allowin(ws_allowin),
        .ms_allowin(ms_allowin), .ms_to_ws_valid(ms_to_ws_valid),
        .es_pc(es_pc), .es_alu_res(es_alu_res), .es_load_op(es_load_op),
        .es_mem_req(es_mem_req), .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr),
        .data_sram_data_ok(data_ok), .data_sram_rdata(rdata),
        .ms_pc(ms_pc), .ms_rf_wdata(ms_rf_wdata), .ms_rf_we(ms_rf_we),
        .ms_rf_waddr(ms_rf_waddr), .ms_blocking(ms_blocking)
    );

    mem_stage_pipe #(.DATA_W(64)) u64 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .es_to_ms_valid(es_to_ms_valid), .ws_allowin(ws_allowin),
        .ms_allowin(ms_allowin64), .ms_to_ws_valid(ms_to_ws_valid64),
        .es_pc(es_pc), .es_alu_res(es_alu_res64), .es_load_op(es_load_op64),
        .es_mem_req(es_mem_req), .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr),
        .data_sram_data_ok(data_ok), .data_sram_rdata(rdata64),
        .ms_pc(ms_pc64), .ms_rf_wdata(ms_rf_wdata64), .ms_rf_we(ms_rf_we64),
        .ms_rf_waddr(ms_rf_waddr64), .ms_blocking(ms_blocking64)
    );

    mem_stage_pipe_chk u_chk (
        .clk(clk), .resetn(resetn), .discard_cnt(u32.discard_cnt_q)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic [2:0] op,
                        input logic req, input logic we, input logic [4:0] waddr);
        es_to_ms_valid = 1'b1;
        es_pc          = pc;
        es_alu_res     = alu;
        es_load_op     = op;
        es_mem_req     = req;
        es_rf_we       = we;
        es_rf_waddr    = waddr;
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; es_to_ms_valid = 1'b0; ws_allowin = 1'b1;
        es_pc = 32'd0; es_alu_res = 32'd0; es_load_op = 3'd0; es_mem_req = 1'b0;
        es_rf_we = 1'b0; es_rf_waddr = 5'd0; data_ok = 1'b0; rdata = 32'd0;
        es_alu_res64 = 64'd0; es_load_op64 = 3'd0; rdata64 = 64'd0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_to_ws", {63'd0, ms_to_ws_valid}, 64'd0);
        check_eq("rst_rf_we", {63'd0, ms_rf_we}, 64'd0);
        check_eq("rst_wdata", {32'd0, ms_rf_wdata}, 64'd0);
        check_eq("rst_pc", {32'd0, ms_pc}, 64'd0);
        check_eq("rst_block", {63'd0, ms_blocking}, 64'd0);
        check_eq("rst_allowin", {63'd0, ms_allowin}, 64'd1);
        resetn = 1'b1;

        // LD.B at 0x1003, response in the first MEM cycle
        send(32'h100, 32'h1003, 3'd1, 1'b1, 1'b1, 5'd3);
        step();
        es_to_ms_valid = 1'b0;
        #1;
        check_eq("t1_block", {63'd0, ms_blocking}, 64'd1);
        check_eq("t1_wait", {63'd0, ms_to_ws_valid}, 64'd0);
        check_eq("t1_nallow", {63'd0, ms_allowin}, 64'd0);
        data_ok = 1'b1; rdata = 32'h80FF_1234;
        #1;
        check_eq("t1_valid", {63'd0, ms_to_ws_valid}, 64'd1);
        check_eq("t1_ldb", {32'd0, ms_rf_wdata}, 64'h0000_0000_FFFF_FF80);
        check_eq("t1_we", {63'd0, ms_rf_we}, 64'd1);
        check_eq("t1_pc", {32'd0, ms_pc}, 64'h100);
        check_eq("t1_waddr", {59'd0, ms_rf_waddr}, 64'd3);
        step();
        data_ok = 1'b0;
        #1;
        check_eq("t1_done", {63'd0, ms_to_ws_valid}, 64'd0);

        // LD.HU at 0x2002 (and 64-bit LD.W at offset 4), next store enters back-to-back
        send(32'h200, 32'h2002, 3'd4, 1'b1, 1'b1, 5'd4);
        es_alu_res64 = 64'd4; es_load_op64 = 3'd5;
        step();
        data_ok = 1'b1; rdata = 32'h8001_0000; rdata64 = 64'hF000_0000_0000_0000;
        send(32'h210, 32'h55, 3'd0, 1'b1, 1'b0, 5'd0);
        es_alu_res64 = 64'd0; es_load_op64 = 3'd0;
        #1;
        check_eq("t2_hu", {32'd0, ms_rf_wdata}, 64'h0000_8001);
        check_eq("t2_valid", {63'd0, ms_to_ws_valid}, 64'd1);
        check_eq("t2_w64", ms_rf_wdata64, 64'hFFFF_FFFF_F000_0000);
        check_eq("t2_valid64", {63'd0, ms_to_ws_valid64}, 64'd1);
        check_eq("t2_b2b_allow", {63'd0, ms_allowin}, 64'd1);
        step();
        data_ok = 1'b0; es_to_ms_valid = 1'b0;
        #1;
        check_eq("t2_st_wait", {63'd0, ms_to_ws_valid}, 64'd0);
        check_eq("t2_st_res", {32'd0, ms_rf_wdata}, 64'h55);
        check_eq("t2_st_we", {63'd0, ms_rf_we}, 64'd0);
        check_eq("t2_st_block", {63'd0, ms_blocking}, 64'd0);
        check_eq("t2_st_pc", {32'd0, ms_pc}, 64'h210);
        data_ok = 1'b1; rdata = 32'hFFFF_FFFF;
        #1;
        check_eq("t2_st_go", {63'd0, ms_to_ws_valid}, 64'd1);
        check_eq("t2_st_res2", {32'd0, ms_rf_wdata}, 64'h55);
        step();
        data_ok = 1'b0;

        // Response arrives while WB is stalled for three cycles
        send(32'h300, 32'h3000, 3'd5, 1'b1, 1'b1, 5'd5);
        step();
        es_to_ms_valid = 1'b0; ws_allowin = 1'b0; data_ok = 1'b1; rdata = 32'h1234_5678;
        #1;
        check_eq("t3_ready", {63'd0, ms_to_ws_valid}, 64'd1);
        check_eq("t3_nallow", {63'd0, ms_allowin}, 64'd0);
        step();
        data_ok = 1'b0; rdata = 32'hAAAA_AAAA;
        #1;
        check_eq("t3_buf", {32'd0, ms_rf_wdata}, 64'h1234_5678);
        check_eq("t3_buf_nallow", {63'd0, ms_allowin}, 64'd0);
        check_eq("t3_buf_valid", {63'd0, ms_to_ws_valid}, 64'd1);
        check_eq("t3_buf_block", {63'd0, ms_blocking}, 64'd0);
        step();
        check_eq("t3_buf2", {32'd0, ms_rf_wdata}, 64'h1234_5678);
        step();
        ws_allowin = 1'b1;
        #1;
        check_eq("t3_deliver", {32'd0, ms_rf_wdata}, 64'h1234_5678);
        check_eq("t3_allow", {63'd0, ms_allowin}, 64'd1);
        check_eq("t3_valid", {63'd0, ms_to_ws_valid}, 64'd1);
        step();
        check_eq("t3_once", {63'd0, ms_to_ws_valid}, 64'd0);

        // Flush orphans a response; the next load must skip it
        send(32'h400, 32'h4000, 3'd5, 1'b1, 1'b1, 5'd6);
        step();
        es_to_ms_valid = 1'b0; flush = 1'b1;
        #1;
        check_eq("t4_flush", {63'd0, ms_to_ws_valid}, 64'd0);
        step();
        flush = 1'b0;
        check_eq("t4_disc1", {62'd0, u32.discard_cnt_q}, 64'd1);
        send(32'h500, 32'h5000, 3'd5, 1'b1, 1'b1, 5'd7);
        #1;
        check_eq("t4_allow", {63'd0, ms_allowin}, 64'd1);
        step();
        es_to_ms_valid = 1'b0; data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
        #1;
        check_eq("t4_drop", {63'd0, ms_to_ws_valid}, 64'd0);
        check_eq("t4_drop_block", {63'd0, ms_blocking}, 64'd1);
        step();
        check_eq("t4_disc0", {62'd0, u32.discard_cnt_q}, 64'd0);
        rdata = 32'h0000_0011;
        #1;
        check_eq("t4_valid", {63'd0, ms_to_ws_valid}, 64'd1);
        check_eq("t4_wdata", {32'd0, ms_rf_wdata}, 64'h11);
        check_eq("t4_waddr", {59'd0, ms_rf_waddr}, 64'd7);
        step();
        data_ok = 1'b0;
        #1;
        check_eq("t4_done", {63'd0, ms_to_ws_valid}, 64'd0);
        check_eq("t4_disc_end", {62'd0, u32.discard_cnt_q}, 64'd0);

        // Asynchronous reset in the middle of a wait
        send(32'h600, 32'h6000, 3'd5, 1'b1, 1'b1, 5'd8);
        step();
        es_to_ms_valid = 1'b0;
        #1;
        check_eq("t5_block", {63'd0, ms_blocking}, 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("t5_to_ws", {63'd0, ms_to_ws_valid}, 64'd0);
        check_eq("t5_rf_we", {63'd0, ms_rf_we}, 64'd0);
        check_eq("t5_wdata", {32'd0, ms_rf_wdata}, 64'd0);
        check_eq("t5_pc", {32'd0, ms_pc}, 64'd0);
        check_eq("t5_blk", {63'd0, ms_blocking}, 64'd0);
        check_eq("t5_waddr", {59'd0, ms_rf_waddr}, 64'd0);
        #1;
        resetn = 1'b1; data_ok = 1'b1; rdata = 32'h99;
        #1;
        check_eq("t5_stale", {63'd0, ms_to_ws_valid}, 64'd0);
        check_eq("t5_allow", {63'd0, ms_allowin}, 64'd1);
        step();
        data_ok = 1'b0;
        #1;
        check_eq("t5_stale2", {63'd0, ms_to_ws_valid}, 64'd0);
        check_eq("t5_we2", {63'd0, ms_rf_we}, 64'd0);
        check_eq("t5_disc", {62'd0, u32.discard_cnt_q}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
